riscv_wb_arbiter: RTL and testbench

Write-back arbiter and register scoreboard in front of the integer/FP register file. It collects results from the single-cycle ALU, the load/store unit and the multi-cycle multiplier/divider. It drives them onto the register file's two write ports as registered write strobes, buffering multiplier results in a small FIFO when the load/store unit holds port B. It also tracks which destination registers have an outstanding write, so the decoder can stall on hazards.

---
 rtl/riscv_wb_pkg.sv | 31 +++
 rtl/riscv_wb_fifo.sv | 74 +++++++
 rtl/riscv_wb_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_riscv_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared types and helpers for the write-back arbiter.
//
// Contents:
//   REG_ZERO      hard-wired zero register address (never written, never busy)
//   INT_BANK_AW   address width of the integer register bank
//   wb_req_t      {addr, data} write request in the default 5/32-bit geometry;
//                 the buffer takes its entry type as a parameter so wider
//                 configurations can reuse the same storage
//   fifo_ptr_w    pointer width for a buffer of a given depth (at least 1)
//   fifo_cnt_w    occupancy counter width (must be able to hold depth itself)
package riscv_wb_pkg;

  localparam int REG_ZERO       = 0;
  localparam int INT_BANK_AW    = 5;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

  function automatic int fifo_ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/riscv_wb_fifo.sv
// Small synchronous FIFO holding multiplier results that could not go
// straight to register-file port B.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset (empties the buffer)
//   push, push_data  write an entry; ignored when full unless popping too
//   pop              remove the head entry; ignored when empty
//   pop_data         current head entry (valid while !empty)
//   full, empty      occupancy flags
//
// A push and a pop in the same cycle are both honoured even when full,
// because the pop frees the slot the push needs.
module riscv_wb_fifo
  import riscv_wb_pkg::*;
#(
  parameter int  FIFO_DEPTH = 2,
  parameter type req_t      = wb_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t pop_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = fifo_ptr_w(FIFO_DEPTH);
  localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  req_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Write-back arbiter and register scoreboard in front of the register file.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   alu_we/waddr/wdata_i             ALU result, no backpressure -> port A
//   lsu_valid/waddr/wdata_i, lsu_ready_o     load result -> port B (priority)
//   mult_valid/waddr/wdata_i, mult_ready_o   mult/div result -> port B
//   issue_i, issue_addr_i            decoder marks a destination as pending
//   raddr_{a,b,c}_i, busy_{a,b,c}_o  hazard queries (combinational)
//   waddr/wdata/we_{a,b}_o           registered register-file write strobes
//   collision_o                      registered pulse: A and B hit one address
//
// Handshake: a result transfers on a rising edge where valid and ready are
// both high; the producer keeps valid and its payload stable until then.
//
// Port B order of preference each cycle: LSU result (any LSU result occupies
// the port, even one to x0 that is then dropped), else the oldest buffered
// multiplier result, else a multiplier result arriving into an empty buffer.
module riscv_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FPU        = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_we_i,
  input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_ready_o,
  input  logic                  mult_valid_i,
  input  logic [ADDR_WIDTH-1:0] mult_waddr_i,
  input  logic [DATA_WIDTH-1:0] mult_wdata_i,
  output logic                  mult_ready_o,
  input  logic                  issue_i,
  input  logic [ADDR_WIDTH-1:0] issue_addr_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  busy_a_o,
  output logic                  busy_b_o,
  output logic                  busy_c_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  output logic                  we_b_o,
  output logic                  collision_o
);

  // Without the FP bank only the integer bank needs scoreboard entries.
  localparam int SB_AW = (FPU != 0) ? ADDR_WIDTH :
                         ((ADDR_WIDTH < INT_BANK_AW) ? ADDR_WIDTH : INT_BANK_AW);
  localparam int SB_ENTRIES = 2 ** SB_AW;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  logic      lsu_take;
  logic      mult_take;
  logic      mult_keep;
  logic      port_b_free;
  logic      bypass;
  logic      fifo_push;
  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;
  wb_entry_t mult_entry;
  wb_entry_t head_entry;

  logic                  we_a_d;
  logic [ADDR_WIDTH-1:0] waddr_a_d;
  logic [DATA_WIDTH-1:0] wdata_a_d;
  logic                  we_b_d;
  logic [ADDR_WIDTH-1:0] waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_b_d;
  logic                  collision_d;

  logic [SB_ENTRIES-1:0] pending_q;
  logic [SB_ENTRIES-1:0] pending_d;

  // ---------------------------------------------------------------- handshakes
  assign lsu_ready_o  = !rst;
  assign mult_ready_o = !rst && !fifo_full;
  assign lsu_take     = lsu_valid_i && lsu_ready_o;
  assign mult_take    = mult_valid_i && mult_ready_o;
  // Results for x0 are accepted but never stored or written.
  assign mult_keep    = mult_take && (mult_waddr_i != ZERO_ADDR);

  // ------------------------------------------------------ multiplier buffering
  assign port_b_free = !rst && !lsu_take;
  // Bypass only into an empty buffer so results never overtake older ones.
  assign bypass      = mult_keep && fifo_empty && port_b_free;
  assign fifo_push   = mult_keep && !bypass;
  assign fifo_pop    = port_b_free && !fifo_empty;
  assign mult_entry  = '{addr: mult_waddr_i, data: mult_wdata_i};

  riscv_wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .req_t      (wb_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mult_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------- next write strobes
  always_comb begin
    we_a_d    = alu_we_i && (alu_waddr_i != ZERO_ADDR);
    waddr_a_d = we_a_d ? alu_waddr_i : '0;
    wdata_a_d = we_a_d ? alu_wdata_i : '0;
  end

  always_comb begin
    we_b_d    = 1'b0;
    waddr_b_d = '0;
    wdata_b_d = '0;
    if (lsu_take) begin
      if (lsu_waddr_i != ZERO_ADDR) begin
        we_b_d    = 1'b1;
        waddr_b_d = lsu_waddr_i;
        wdata_b_d = lsu_wdata_i;
      end
    end else if (fifo_pop) begin
      we_b_d    = 1'b1;
      waddr_b_d = head_entry.addr;
      wdata_b_d = head_entry.data;
    end else if (bypass) begin
      we_b_d    = 1'b1;
      waddr_b_d = mult_waddr_i;
      wdata_b_d = mult_wdata_i;
    end
  end

  assign collision_d = we_a_d && we_b_d && (waddr_a_d == waddr_b_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      we_a_o      <= 1'b0;
      waddr_a_o   <= '0;
      wdata_a_o   <= '0;
      we_b_o      <= 1'b0;
      waddr_b_o   <= '0;
      wdata_b_o   <= '0;
      collision_o <= 1'b0;
    end else begin
      we_a_o      <= we_a_d;
      waddr_a_o   <= waddr_a_d;
      wdata_a_o   <= wdata_a_d;
      we_b_o      <= we_b_d;
      waddr_b_o   <= waddr_b_d;
      wdata_b_o   <= wdata_b_d;
      collision_o <= collision_d;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  // The clear comes from the strobe being written this cycle; the set is
  // applied afterwards so a re-issue of the same register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (we_b_o) begin
      pending_d[waddr_b_o[SB_AW-1:0]] = 1'b0;
    end
    if (issue_i && (issue_addr_i != ZERO_ADDR)) begin
      pending_d[issue_addr_i[SB_AW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign busy_a_o = (raddr_a_i != ZERO_ADDR) && pending_q[raddr_a_i[SB_AW-1:0]];
  assign busy_b_o = (raddr_b_i != ZERO_ADDR) && pending_q[raddr_b_i[SB_AW-1:0]];
  assign busy_c_o = (raddr_c_i != ZERO_ADDR) && pending_q[raddr_c_i[SB_AW-1:0]];

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_riscv_wb_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  // ------------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          alu_we_i;
  logic [AW-1:0] alu_waddr_i;
  logic [DW-1:0] alu_wdata_i;
  logic          lsu_valid_i;
  logic [AW-1:0] lsu_waddr_i;
  logic [DW-1:0] lsu_wdata_i;
  logic          lsu_ready_o;
  logic          mult_valid_i;
  logic [AW-1:0] mult_waddr_i;
  logic [DW-1:0] mult_wdata_i;
  logic          mult_ready_o;
  logic          issue_i;
  logic [AW-1:0] issue_addr_i;
  logic [AW-1:0] raddr_a_i, raddr_b_i, raddr_c_i;
  logic          busy_a_o, busy_b_o, busy_c_o;
  logic [AW-1:0] waddr_a_o, waddr_b_o;
  logic [DW-1:0] wdata_a_o, wdata_b_o;
  logic          we_a_o, we_b_o, collision_o;

  riscv_wb_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FPU        (0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_we_i     (alu_we_i),
    .alu_waddr_i  (alu_waddr_i),
    .alu_wdata_i  (alu_wdata_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_waddr_i  (lsu_waddr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_ready_o  (lsu_ready_o),
    .mult_valid_i (mult_valid_i),
    .mult_waddr_i (mult_waddr_i),
    .mult_wdata_i (mult_wdata_i),
    .mult_ready_o (mult_ready_o),
    .issue_i      (issue_i),
    .issue_addr_i (issue_addr_i),
    .raddr_a_i    (raddr_a_i),
    .raddr_b_i    (raddr_b_i),
    .raddr_c_i    (raddr_c_i),
    .busy_a_o     (busy_a_o),
    .busy_b_o     (busy_b_o),
    .busy_c_o     (busy_c_o),
    .waddr_a_o    (waddr_a_o),
    .wdata_a_o    (wdata_a_o),
    .we_a_o       (we_a_o),
    .waddr_b_o    (waddr_b_o),
    .wdata_b_o    (wdata_b_o),
    .we_b_o       (we_b_o),
    .collision_o  (collision_o)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: multiplier results waiting for port B in arrival order,
  // one pending flag per register, and the strobes expected next cycle.
  logic [AW+DW-1:0] exp_q[$];
  bit               pend [2**AW];
  logic             e_we_a, e_we_b, e_coll;
  logic [AW-1:0]    e_addr_a, e_addr_b;
  logic [DW-1:0]    e_data_a, e_data_b;
  bit               last_rst;
  bit               mult_acc;

  task automatic model_step();
    logic [AW+DW-1:0] ent;
    last_rst = rst;
    mult_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      e_we_a = 0; e_addr_a = '0; e_data_a = '0;
      e_we_b = 0; e_addr_b = '0; e_data_b = '0;
      e_coll = 0;
      return;
    end
    // The write being presented now retires its register; a new issue
    // to the same register keeps it pending.
    if (e_we_b) pend[e_addr_b] = 1'b0;
    if (issue_i && issue_addr_i != 0) pend[issue_addr_i] = 1'b1;
    mult_acc = mult_valid_i && (exp_q.size() < DEPTH);
    if (mult_acc && mult_waddr_i != 0) exp_q.push_back({mult_waddr_i, mult_wdata_i});
    e_we_a   = alu_we_i && (alu_waddr_i != 0);
    e_addr_a = e_we_a ? alu_waddr_i : '0;
    e_data_a = e_we_a ? alu_wdata_i : '0;
    e_we_b = 0; e_addr_b = '0; e_data_b = '0;
    if (lsu_valid_i) begin
      if (lsu_waddr_i != 0) begin
        e_we_b = 1; e_addr_b = lsu_waddr_i; e_data_b = lsu_wdata_i;
      end
    end else if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      e_we_b = 1; e_addr_b = ent[AW+DW-1:DW]; e_data_b = ent[DW-1:0];
    end
    e_coll = e_we_a && e_we_b && (e_addr_a == e_addr_b);
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic idle();
    alu_we_i = 0; lsu_valid_i = 0; mult_valid_i = 0; issue_i = 0;
  endtask

  // Inputs are set just after a falling edge; combinational outputs are
  // checked 1 ns later, registered outputs 1 ns after the rising edge.
  task automatic cycle();
    #1;
    check("lsu_ready", lsu_ready_o, !rst);
    check("mult_ready", mult_ready_o, !rst && (exp_q.size() < DEPTH));
    check("busy_a", busy_a_o, (raddr_a_i != 0) && pend[raddr_a_i]);
    check("busy_b", busy_b_o, (raddr_b_i != 0) && pend[raddr_b_i]);
    check("busy_c", busy_c_o, (raddr_c_i != 0) && pend[raddr_c_i]);
    @(posedge clk);
    model_step();
    #1;
    check("we_a", we_a_o, e_we_a);
    check("we_b", we_b_o, e_we_b);
    check("collision", collision_o, e_coll);
    if (e_we_a || last_rst) begin
      check("waddr_a", waddr_a_o, e_addr_a);
      check("wdata_a", wdata_a_o, e_data_a);
    end
    if (e_we_b || last_rst) begin
      check("waddr_b", waddr_b_o, e_addr_b);
      check("wdata_b", wdata_b_o, e_data_b);
    end
    @(negedge clk);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int idx;
    idle();
    rst = 1;
    alu_waddr_i = '0; alu_wdata_i = '0;
    lsu_waddr_i = '0; lsu_wdata_i = '0;
    mult_waddr_i = '0; mult_wdata_i = '0;
    issue_addr_i = '0;
    raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0;
    @(negedge clk);
    cycle();
    cycle();
    check("rst_we_b", we_b_o, 0);
    rst = 0;

    // ALU write to x5 lands on port A for exactly one cycle.
    alu_we_i = 1; alu_waddr_i = 5; alu_wdata_i = 32'hDEADBEEF;
    cycle();
    idle();
    check("alu_x5_we", we_a_o, 1);
    check("alu_x5_data", wdata_a_o, 32'hDEADBEEF);
    cycle();
    check("alu_x5_one_cycle", we_a_o, 0);

    // Issue x7, then its mult result bypasses to port B.
    raddr_a_i = 7; issue_i = 1; issue_addr_i = 7;
    cycle();
    issue_i = 0;
    check("x7_busy_set", busy_a_o, 1);
    mult_valid_i = 1; mult_waddr_i = 7; mult_wdata_i = 32'h12;
    cycle();
    mult_valid_i = 0;
    check("x7_we_b", we_b_o, 1);
    check("x7_waddr_b", waddr_b_o, 7);
    check("x7_busy_during_strobe", busy_a_o, 1);
    cycle();
    check("x7_busy_clear", busy_a_o, 0);

    // LSU holds port B for 4 cycles while 3 mult results queue up.
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      lsu_valid_i  = (c < 4);
      lsu_waddr_i  = AW'(10 + c);
      lsu_wdata_i  = $urandom;
      mult_valid_i = (idx < 3);
      mult_waddr_i = AW'(20 + idx);
      mult_wdata_i = 32'hA0 + DW'(idx);
      if (c == 2) check("burst_mult_ready_low", mult_ready_o, 0);
      cycle();
      if (mult_acc) idx++;
      if (c >= 4 && c <= 6) begin
        check("burst_we_b", we_b_o, 1);
        check("burst_order", waddr_b_o, 20 + c - 4);
      end
    end
    idle();

    // Re-issue of x9 in the same cycle its write retires keeps it pending.
    raddr_b_i = 9; issue_i = 1; issue_addr_i = 9;
    cycle();
    issue_i = 0;
    lsu_valid_i = 1; lsu_waddr_i = 9; lsu_wdata_i = 32'h99;
    cycle();
    lsu_valid_i = 0;
    issue_i = 1; issue_addr_i = 9;
    check("x9_we_b", we_b_o, 1);
    cycle();
    issue_i = 0;
    check("x9_set_wins", busy_b_o, 1);

    // ALU and LSU both hit x3, then an ALU write to x0.
    alu_we_i = 1; alu_waddr_i = 3; alu_wdata_i = 32'h33;
    lsu_valid_i = 1; lsu_waddr_i = 3; lsu_wdata_i = 32'h44;
    cycle();
    idle();
    check("coll_pulse", collision_o, 1);
    check("coll_we_a", we_a_o, 1);
    check("coll_we_b", we_b_o, 1);
    alu_we_i = 1; alu_waddr_i = 0; alu_wdata_i = 32'h55;
    cycle();
    idle();
    check("coll_one_cycle", collision_o, 0);
    check("x0_no_strobe", we_a_o, 0);

    // Fill the buffer and three pending bits, then reset.
    for (int c = 0; c < 3; c++) begin
      lsu_valid_i = 1; lsu_waddr_i = 15; lsu_wdata_i = $urandom;
      mult_valid_i = (c < 2); mult_waddr_i = AW'(24 + c); mult_wdata_i = $urandom;
      issue_i = 1; issue_addr_i = AW'(11 + c);
      cycle();
    end
    idle();
    check("pre_rst_full", mult_ready_o, 0);
    raddr_a_i = 11; raddr_b_i = 12; raddr_c_i = 13;
    rst = 1;
    cycle();
    rst = 0;
    check("rst_busy_a", busy_a_o, 0);
    check("rst_busy_b", busy_b_o, 0);
    check("rst_busy_c", busy_c_o, 0);
    check("rst_no_we_b", we_b_o, 0);
    cycle();
    check("post_rst_no_drain", we_b_o, 0);

    // Randomized traffic; the mult producer holds its result until accepted.
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      alu_we_i     = 1'($urandom_range(0, 1));
      alu_waddr_i  = AW'($urandom_range(0, 31));
      alu_wdata_i  = $urandom;
      lsu_valid_i  = ($urandom_range(0, 2) == 0);
      lsu_waddr_i  = AW'($urandom_range(1, 31));
      lsu_wdata_i  = $urandom;
      if (!mult_valid_i || mult_acc) begin
        mult_valid_i = 1'($urandom_range(0, 1));
        mult_waddr_i = AW'($urandom_range(0, 31));
        mult_wdata_i = $urandom;
      end
      issue_i      = ($urandom_range(0, 3) == 0);
      issue_addr_i = AW'($urandom_range(0, 31));
      raddr_a_i    = AW'($urandom_range(0, 31));
      raddr_b_i    = AW'($urandom_range(0, 31));
      raddr_c_i    = AW'($urandom_range(0, 31));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
